mult_arb_seq: RTL and testbench
===============================

MULT_ARB_SEQ -- requirements
Module: mult_arb_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 req  input  2  level request per requester; bit 0 is requester 0 and bit 1 is requester 1.
REQ-005 a0, b0  input  4 each  requester 0 operands; held stable while req[0]=1.
REQ-006 a1, b1  input  4 each  requester 1 operands; held stable while req[1]=1.
REQ-007 gnt  output  2  one-hot, one-cycle pulse when the operands of that requester are captured.
REQ-008 busy  output  1  high while a multiplication is in progress (CALC or DONE state).
REQ-009 done  output  1  one-cycle pulse when out holds a new product.
REQ-010 done_id  output  1  index of the requester that owns the current out value.
REQ-011 out  output  8  unsigned product; holds its value until the next done.

Function
REQ-012 The block SHALL share one 8-bit shift-add datapath (accumulator plus one 8-bit add per cycle) between the two requesters.
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 IDLE: if req=00, the FSM SHALL remain in IDLE.
- Otherwise, at the clock edge, it SHALL select a winner, latch that requester's a and b into a_reg and b_reg, clear acc and step, set the gnt bit of the winner for the next cycle, and go to CALC.
REQ-015 Arbitration SHALL be round-robin with a 1-bit last-served pointer.
- If only one request is active, that request wins.
- If both are active, the requester not served last wins.
- The pointer SHALL update on every grant and reset to 1, so requester 0 wins the first tie.
REQ-016 CALC SHALL last exactly 4 cycles (step 0..3).
- Each cycle: acc <= acc + ({4'b0,a_reg} << step) if b_reg[step]=1, else acc is unchanged.
- Additions wrap modulo 256; the maximum product is 225, so no overflow can occur.
- After step 3 the FSM SHALL go to DONE.
REQ-017 On entry to DONE, out <= final acc and done_id <= winner.
- done SHALL be 1 for exactly the DONE cycle.
- The FSM SHALL then return to IDLE unconditionally.
REQ-018 Latency and throughput:
- gnt is high in the first CALC cycle.
- done is high 4 cycles after gnt.
- The earliest next gnt is 2 cycles after done, so one operation completes every 6 cycles under continuous requests.
REQ-019 Requests SHALL be sampled only in IDLE; req changes during CALC or DONE have no effect.
REQ-020 A request withdrawn before its grant SHALL be ignored, with no gnt and no state change.
REQ-021 Operands SHALL be sampled only at grant; input changes after grant do not affect the result.
REQ-022 A zero operand SHALL still take the full 4-cycle CALC latency; there is no early termination.
REQ-023 At most one gnt bit, and at most one of gnt or done, SHALL be high in any cycle.

Reset
REQ-024 While reset=1, the block SHALL force the following, regardless of clk:
- state=IDLE; acc, a_reg, b_reg, step = 0; pointer = 1.
- gnt=00, busy=0, done=0, done_id=0, out=8'h00.
REQ-025 Reset asserted during CALC or DONE SHALL abort the operation: no done is produced and out reads 8'h00.
REQ-026 After reset is released, the first grant SHALL require a req sampled at a clock edge with reset=0.

Verification
REQ-027 Assert reset mid-simulation -> all outputs 0 and busy=0 within the same cycle, without a clock edge.
REQ-028 req=01, a0=4'hF, b0=4'hF -> gnt=01 next cycle; 4 cycles later done=1, out=8'hE1, done_id=0.
REQ-029 req=11 after reset, a0=3, b0=5, a1=7, b1=9 -> first gnt=01, done with out=8'h0F and done_id=0; then gnt=10, done with out=8'h3F and done_id=1.
REQ-030 req=10, a1=0, b1=4'hC -> done exactly 4 cycles after gnt, out=8'h00.
REQ-031 reset pulsed in the 3rd CALC cycle of a 6x6 operation -> no done; out=8'h00; a later request completes normally with the correct product.
REQ-032 req held at 01 continuously, operands changed right after each gnt -> gnt[0] every 6 cycles; each out matches the operands captured at its gnt; a1/b1 changes never affect out.

Source files
------------

// File: rtl/mult_arb_seq_if.sv
// rtl/mult_arb_seq_if.sv - request/operand and result bundle for the shared multiplier
interface mult_arb_seq_if;
  logic [1:0] req;
  logic [3:0] a0;
  logic [3:0] b0;
  logic [3:0] a1;
  logic [3:0] b1;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       done_id;
  logic [7:0] out;

  modport master (
    output req, a0, b0, a1, b1,
    input  gnt, busy, done, done_id, out
  );

  modport slave (
    input  req, a0, b0, a1, b1,
    output gnt, busy, done, done_id, out
  );
endinterface

// File: rtl/mult_arb_seq.sv
// rtl/mult_arb_seq.sv - two-requester round-robin arbiter sharing one 4x4 shift-add multiplier
module mult_arb_seq (
  input  logic          clk,
  input  logic          reset,
  mult_arb_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic [3:0] a_reg;
  logic [3:0] b_reg;
  logic [7:0] acc;
  logic [1:0] step;
  logic       last;
  logic       winner;
  logic       win;
  logic [1:0] gnt_q;
  logic       busy_q;
  logic       done_q;
  logic       done_id_q;
  logic [7:0] out_q;
  logic [7:0] addend;
  logic [7:0] acc_nxt;

  // Tie goes to whoever was not served last; pointer resets to 1 so requester 0 wins first.
  always_comb begin
    win = 1'b0;
    case (bus.req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

  assign addend  = b_reg[step] ? ({4'b0000, a_reg} << step) : 8'h00;
  assign acc_nxt = acc + addend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= 4'h0;
      b_reg     <= 4'h0;
      acc       <= 8'h00;
      step      <= 2'd0;
      last      <= 1'b1;
      winner    <= 1'b0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      out_q     <= 8'h00;
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            a_reg  <= win ? bus.a1 : bus.a0;
            b_reg  <= win ? bus.b1 : bus.b0;
            acc    <= 8'h00;
            step   <= 2'd0;
            winner <= win;
            last   <= win;
            gnt_q  <= win ? 2'b10 : 2'b01;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_nxt;
          step <= step + 2'd1;
          // The last partial product goes straight to out so done lines up with DONE.
          if (step == 2'd3) begin
            out_q     <= acc_nxt;
            done_q    <= 1'b1;
            done_id_q <= winner;
            state     <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.out     = out_q;

endmodule

// File: tb/tb_mult_arb_seq.sv
// tb/tb_mult_arb_seq.sv - directed scoreboard bench for mult_arb_seq
module tb_mult_arb_seq;

  typedef struct {
    logic       id;
    logic [7:0] prod;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;
  exp_t sb[$];

  mult_arb_seq_if bus ();

  mult_arb_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.id   = id;
    e.prod = 8'({4'h0, a} * {4'h0, b});
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input logic [1:0] exp_gnt, output int gcyc);
    logic found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.gnt != 2'b00) begin
        found = 1'b1;
        break;
      end
    end
    gcyc = cyc;
    check("gnt_seen", 32'(found), 32'd1);
    check("gnt_value", 32'(bus.gnt), 32'(exp_gnt));
    check("busy_at_gnt", 32'(bus.busy), 32'd1);
    check("no_done_at_gnt", 32'(bus.done), 32'd0);
  endtask

  task automatic wait_done(input int gcyc);
    logic found = 1'b0;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(found), 32'd1);
    if (found) begin
      last_done_cyc = cyc;
      check("done_latency", 32'(cyc - gcyc), 32'd4);
      check("gnt_low_at_done", 32'(bus.gnt), 32'd0);
      if (sb.size() == 0) begin
        check("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check("out", 32'(bus.out), 32'(e.prod));
        check("done_id", 32'(bus.done_id), 32'(e.id));
      end
    end
  endtask

  initial begin
    int g;
    int gp;
    int seen;
    logic [3:0] x;
    logic [3:0] y;

    bus.req = 2'b00;
    bus.a0 = 4'h0; bus.b0 = 4'h0; bus.a1 = 4'h0; bus.b1 = 4'h0;
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_done_id", 32'(bus.done_id), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_no_gnt", 32'(bus.gnt), 32'd0);

    // 15 x 15 from requester 0
    bus.a0 = 4'hF; bus.b0 = 4'hF; bus.req = 2'b01;
    push(1'b0, 4'hF, 4'hF);
    wait_gnt(2'b01, g);
    bus.req = 2'b00;
    wait_done(g);

    // tie right after reset: requester 0 first, then requester 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.a0 = 4'd3; bus.b0 = 4'd5; bus.a1 = 4'd7; bus.b1 = 4'd9; bus.req = 2'b11;
    push(1'b0, 4'd3, 4'd5);
    push(1'b1, 4'd7, 4'd9);
    wait_gnt(2'b01, g);
    wait_done(g);
    wait_gnt(2'b10, g);
    check("tie_gap_after_done", 32'(g - last_done_cyc), 32'd2);
    bus.req = 2'b00;
    wait_done(g);

    // abort a 6 x 6 in its third CALC cycle with an edge-free reset
    bus.a0 = 4'd6; bus.b0 = 4'd6; bus.req = 2'b01;
    wait_gnt(2'b01, g);
    bus.req = 2'b00;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("abort_gnt", 32'(bus.gnt), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_done_id", 32'(bus.done_id), 32'd0);
    check("abort_out", 32'(bus.out), 32'd0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done || bus.gnt != 2'b00) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);
    check("abort_out_hold", 32'(bus.out), 32'd0);
    bus.req = 2'b01;
    push(1'b0, 4'd6, 4'd6);
    wait_gnt(2'b01, g);
    bus.req = 2'b00;
    wait_done(g);

    // zero operand still takes the full latency
    bus.a1 = 4'h0; bus.b1 = 4'hC; bus.req = 2'b10;
    push(1'b1, 4'h0, 4'hC);
    wait_gnt(2'b10, g);
    bus.req = 2'b00;
    wait_done(g);

    // continuous requester 0, operands changed right after each grant
    x = 4'($urandom_range(0, 15));
    y = 4'($urandom_range(0, 15));
    bus.a0 = x; bus.b0 = y; bus.req = 2'b01;
    push(1'b0, x, y);
    gp = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(2'b01, g);
      if (k > 0) check("pipeline_gap", 32'(g - gp), 32'd6);
      gp = g;
      if (k < 3) begin
        x = 4'($urandom_range(0, 15));
        y = 4'($urandom_range(0, 15));
        bus.a0 = x; bus.b0 = y;
        push(1'b0, x, y);
      end else begin
        bus.req = 2'b00;
      end
      bus.a1 = 4'($urandom_range(0, 15));
      bus.b1 = 4'($urandom_range(0, 15));
      wait_done(g);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
